// File: rtl/adder_arbiter_if.sv
// Request, response and shared-adder signals between requesters, the arbiter and the adder.
// slave is the arbiter side; master is the requester/consumer/adder side.
interface adder_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = $clog2(NREQ)
) ();
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic [WIDTH-1:0]      add_sum;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [IDW-1:0]        resp_id;
    logic [WIDTH-1:0]      resp_sum;
    logic                  resp_carry;

    modport slave (
        input  req_valid, req_a, req_b, add_sum, resp_ready,
        output req_ready, add_a, add_b, resp_valid, resp_id, resp_sum, resp_carry
    );

    modport master (
        output req_valid, req_a, req_b, add_sum, resp_ready,
        input  req_ready, add_a, add_b, resp_valid, resp_id, resp_sum, resp_carry
    );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one external adder among NREQ requesters; response 2 edges after grant.
// resp_ready low holds the response stable and stalls every requester (req_ready stays zero).
module adder_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic           clk,
    input  logic           rst,
    adder_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;

    state_t           state, state_nxt;
    logic [IDW-1:0]   last;
    logic [IDW-1:0]   gnt_idx;
    logic [IDW-1:0]   cand;
    logic             gnt_vld;
    logic [NREQ-1:0]  req_ready_w;
    logic [WIDTH-1:0] op_a [NREQ];
    logic [WIDTH-1:0] op_b [NREQ];

    logic [WIDTH-1:0] add_a_q, add_b_q, resp_sum_q;
    logic [IDW-1:0]   resp_id_q;
    logic             resp_valid_q, resp_carry_q;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign op_a[g] = bus.req_a[g*WIDTH +: WIDTH];
        assign op_b[g] = bus.req_b[g*WIDTH +: WIDTH];
    end

    // Scan downward so the closest requester after 'last' is the final one written.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = NREQ; i >= 1; i--) begin
            cand = IDW'((int'(last) + i) % NREQ);
            if (bus.req_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready_w = '0;
        if (state == IDLE && !rst && gnt_vld) begin
            req_ready_w[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_vld) state_nxt = ADD;
            ADD:     state_nxt = RESP;
            RESP:    if (bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last         <= IDW'(NREQ - 1);
            add_a_q      <= '0;
            add_b_q      <= '0;
            resp_id_q    <= '0;
            resp_sum_q   <= '0;
            resp_carry_q <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        add_a_q   <= op_a[gnt_idx];
                        add_b_q   <= op_b[gnt_idx];
                        resp_id_q <= gnt_idx;
                        last      <= gnt_idx;
                    end
                end
                ADD: begin
                    // Wrap-around of an unsigned add shows up as a sum below either operand.
                    resp_sum_q   <= bus.add_sum;
                    resp_carry_q <= (bus.add_sum < add_a_q);
                    resp_valid_q <= 1'b1;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_w;
    assign bus.add_a      = add_a_q;
    assign bus.add_b      = add_b_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_sum   = resp_sum_q;
    assign bus.resp_carry = resp_carry_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: vector table for single transactions plus
// hand-written round-robin, fairness, backpressure and mid-operation reset sequences.
module tb_adder_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int IDW   = 2;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adder_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

    // Behavioural stand-in for the shared adder.
    assign bus.add_sum = bus.add_a + bus.add_b;

    adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        logic        carry;
    } vec_t;

    vec_t vecs [7];

    int          g_idx [$];
    int          g_cyc [$];
    int          r_id  [$];
    logic [31:0] r_sum [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int id, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[id*WIDTH +: WIDTH] = a;
        bus.req_b[id*WIDTH +: WIDTH] = b;
    endtask

    // Record grants and accepted responses; a granted requester drops its valid after the grant edge.
    task automatic capture(input int max_cyc, input int want_resp);
        logic [NREQ-1:0] gb;
        int nr;
        nr = 0;
        g_idx.delete(); g_cyc.delete(); r_id.delete(); r_sum.delete();
        for (int c = 0; c < max_cyc && nr < want_resp; c++) begin
            @(negedge clk);
            gb = bus.req_ready;
            if (gb != '0) begin
                for (int k = 0; k < NREQ; k++) if (gb[k]) g_idx.push_back(k);
                g_cyc.push_back(cyc);
            end
            if (bus.resp_valid && bus.resp_ready) begin
                r_id.push_back(int'(bus.resp_id));
                r_sum.push_back(bus.resp_sum);
                nr++;
            end
            step();
            bus.req_valid = bus.req_valid & ~gb;
        end
        chk("capture_resp_count", nr, want_resp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2, 32'h0000000F, 32'h00000007, 32'h00000016, 1'b0};
        vecs[1] = '{0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
        vecs[2] = '{3, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1};
        vecs[3] = '{1, 32'h12345678, 32'h9ABCDEF0, 32'hACF13568, 1'b0};
        vecs[4] = '{2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1};
        vecs[5] = '{1, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
        vecs[6] = '{0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0};

        rst            = 1'b1;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b0;
        step();
        step();

        // Reset state, with every requester asking
        bus.req_valid = '1;
        @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_add_a", bus.add_a, 0);
        chk("rst_add_b", bus.add_b, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_id", bus.resp_id, 0);
        chk("rst_resp_sum", bus.resp_sum, 0);
        chk("rst_resp_carry", bus.resp_carry, 0);
        step();
        rst = 1'b0;
        bus.req_valid = '0;

        // Single-requester vectors
        bus.resp_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            step();
            set_op(vecs[v].id, vecs[v].a, vecs[v].b);
            bus.req_valid = NREQ'(1 << vecs[v].id);
            @(negedge clk);
            chk("vec_req_ready", bus.req_ready, 64'(1 << vecs[v].id));
            step();
            bus.req_valid = '0;
            @(negedge clk);
            chk("vec_add_req_ready", bus.req_ready, 0);
            chk("vec_add_a", bus.add_a, vecs[v].a);
            chk("vec_add_b", bus.add_b, vecs[v].b);
            chk("vec_early_valid", bus.resp_valid, 0);
            step();
            @(negedge clk);
            chk("vec_resp_valid", bus.resp_valid, 1);
            chk("vec_resp_id", bus.resp_id, vecs[v].id);
            chk("vec_resp_sum", bus.resp_sum, vecs[v].sum);
            chk("vec_resp_carry", bus.resp_carry, vecs[v].carry);
            step();
            @(negedge clk);
            chk("vec_valid_clear", bus.resp_valid, 0);
        end

        // All four valid from reset: grants 0,1,2,3 three cycles apart
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int g = 0; g < NREQ; g++) set_op(g, 32'h100 * (g + 1), g + 1);
        bus.req_valid = '1;
        capture(40, 4);
        chk("rr_grant_count", g_idx.size(), 4);
        if (g_idx.size() == 4 && r_id.size() == 4) begin
            for (int g = 0; g < NREQ; g++) begin
                chk("rr_grant_order", g_idx[g], g);
                chk("rr_resp_id", r_id[g], g);
                chk("rr_resp_sum", r_sum[g], 32'h101 * (g + 1));
                if (g > 0) chk("rr_grant_spacing", g_cyc[g] - g_cyc[g-1], 3);
            end
        end

        // Fairness: after 2 is granted, 3 is served before 1
        set_op(2, 32'h5, 32'h6);
        set_op(3, 32'h10, 32'h20);
        set_op(1, 32'hAAAA0000, 32'h00005555);
        bus.req_valid = 4'b0100;
        @(negedge clk);
        chk("fair_first_grant", bus.req_ready, 4'b0100);
        step();
        bus.req_valid = 4'b1010;
        capture(40, 3);
        chk("fair_grant_count", g_idx.size(), 2);
        if (g_idx.size() == 2) begin
            chk("fair_grant0", g_idx[0], 3);
            chk("fair_grant1", g_idx[1], 1);
        end
        if (r_id.size() == 3) begin
            chk("fair_resp_id0", r_id[0], 2);
            chk("fair_resp_sum0", r_sum[0], 32'h0000000B);
            chk("fair_resp_id1", r_id[1], 3);
            chk("fair_resp_sum1", r_sum[1], 32'h00000030);
            chk("fair_resp_id2", r_id[2], 1);
            chk("fair_resp_sum2", r_sum[2], 32'hAAAA5555);
        end

        // Backpressure: response held for 5 cycles while requester 0 waits
        bus.resp_ready = 1'b0;
        step();
        set_op(1, 32'hDEADBEEF, 32'h11111111);
        set_op(0, 32'h00000001, 32'h00000002);
        bus.req_valid = 4'b0010;
        @(negedge clk);
        chk("bp_grant", bus.req_ready, 4'b0010);
        step();
        bus.req_valid = 4'b0001;
        step();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_hold_valid", bus.resp_valid, 1);
            chk("bp_hold_id", bus.resp_id, 1);
            chk("bp_hold_sum", bus.resp_sum, 32'hEFBED000);
            chk("bp_hold_carry", bus.resp_carry, 0);
            chk("bp_req_ready", bus.req_ready, 0);
            step();
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", bus.resp_valid, 1);
        chk("bp_release_req_ready", bus.req_ready, 0);
        step();
        @(negedge clk);
        chk("bp_done_valid", bus.resp_valid, 0);
        chk("bp_next_grant", bus.req_ready, 4'b0001);
        step();
        bus.req_valid = '0;
        step();
        @(negedge clk);
        chk("bp_next_sum", bus.resp_sum, 32'h00000003);
        chk("bp_next_id", bus.resp_id, 0);
        step();

        // Reset while in ADD
        bus.resp_ready = 1'b0;
        set_op(1, 32'h00000055, 32'h000000AA);
        bus.req_valid = 4'b0010;
        @(negedge clk);
        chk("radd_grant", bus.req_ready, 4'b0010);
        step();
        rst = 1'b1;
        bus.req_valid = 4'b0111;
        step();
        @(negedge clk);
        chk("radd_req_ready", bus.req_ready, 0);
        chk("radd_add_a", bus.add_a, 0);
        chk("radd_add_b", bus.add_b, 0);
        chk("radd_resp_valid", bus.resp_valid, 0);
        chk("radd_resp_id", bus.resp_id, 0);
        rst = 1'b0;
        #1;
        chk("radd_next_grant", bus.req_ready, 4'b0001);

        // Reset while in RESP
        set_op(0, 32'h0F0F0F0F, 32'h01010101);
        step();
        step();
        @(negedge clk);
        chk("rresp_valid", bus.resp_valid, 1);
        chk("rresp_id", bus.resp_id, 0);
        chk("rresp_sum", bus.resp_sum, 32'h10101010);
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("rresp_valid_cleared", bus.resp_valid, 0);
        chk("rresp_sum_cleared", bus.resp_sum, 0);
        chk("rresp_carry_cleared", bus.resp_carry, 0);
        chk("rresp_add_a_cleared", bus.add_a, 0);
        rst = 1'b0;
        #1;
        chk("rresp_next_grant", bus.req_ready, 4'b0001);
        bus.req_valid = '0;
        bus.resp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            @(negedge clk);
            chk("rresp_no_response", bus.resp_valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
